// File: rtl/fir_pkg.sv
// Shared types and widths for the FIR sequencer and its sample FIFO.
package fir_pkg;

  localparam int FP16_W  = 16;
  localparam int FP16I_W = 17;

  localparam int DW_DEF = FP16_W;
  localparam int CW_DEF = FP16I_W;

  typedef enum logic [2:0] {
    IDLE,
    CL_WAIT,
    CL_SETUP,
    CL_STROBE,
    RUN
  } fir_state_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// Input sample FIFO. Flags are registered; full is held high through reset
// so the upstream source stalls until the FIFO is out of reset.
module fir_sample_fifo import fir_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Occupancy after this cycle; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointers, occupancy and the registered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b1;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_CNT);
      empty <= (count_nxt == '0);
    end
  end

  // Storage is not reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer in front of the W4823 FIR core: coefficient load, then paced
// sample issue and result capture.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for cfg_start
// CL_WAIT   | coef_ready high, waiting for a coefficient word
// CL_SETUP  | caddr/cin set up on the CMEM port, cload low
// CL_STROBE | cload high for one cycle; last word moves on to RUN
// RUN       | frame-paced sample issue and result capture; left only by reset
module fir_seq_ctrl import fir_pkg::*; #(
  parameter int NTAPS        = 64,
  parameter int FRAME_CYCLES = 256,
  parameter int FIFO_DEPTH   = 4,
  parameter int DW           = DW_DEF,
  parameter int CW           = CW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic                     coef_valid,
  input  logic [CW-1:0]            coef_data,
  output logic                     coef_ready,
  input  logic                     s_valid,
  input  logic [DW-1:0]            s_data,
  output logic                     s_ready,
  output logic                     m_valid,
  output logic [DW-1:0]            m_data,
  input  logic                     m_ready,
  output logic [CW-1:0]            fir_cin,
  output logic [$clog2(NTAPS)-1:0] fir_caddr,
  output logic                     fir_cload,
  output logic [DW-1:0]            fir_din,
  output logic                     fir_valid_in,
  input  logic [DW-1:0]            fir_dout,
  input  logic                     fir_valid,
  output logic                     busy,
  output logic                     run,
  output logic                     ovf,
  output logic                     udf
);

  localparam int CAW = $clog2(NTAPS);
  localparam int FCW = $clog2(FRAME_CYCLES);
  localparam logic [CAW-1:0] LAST_ADDR    = CAW'(NTAPS - 1);
  localparam logic [FCW-1:0] FRAME_RELOAD = FCW'(FRAME_CYCLES - 1);

  fir_state_t     state_q;
  fir_state_t     state_d;
  logic [CAW-1:0] coef_cnt;
  logic [FCW-1:0] frame_cnt;
  logic           coef_hs;
  logic           slot;
  logic           fifo_full;
  logic           fifo_empty;
  logic [DW-1:0]  fifo_head;
  logic           fv_q;
  logic           fv_q2;
  logic           res_evt;

  assign coef_hs = coef_valid && coef_ready;
  // The frame timer counts down; a sample slot is its terminal count.
  assign slot    = (state_q == RUN) && (frame_cnt == '0);
  // Result event is the registered rising edge, one cycle after it occurs.
  assign res_evt = (state_q == RUN) && fv_q && !fv_q2;
  assign s_ready = !fifo_full;

  fir_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s_valid && s_ready),
    .push_data (s_data),
    .pop       (slot),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cfg_start) state_d = CL_WAIT;
      CL_WAIT:   if (coef_hs) state_d = CL_SETUP;
      CL_SETUP:  state_d = CL_STROBE;
      CL_STROBE: state_d = (coef_cnt == LAST_ADDR) ? RUN : CL_WAIT;
      RUN:       state_d = RUN;
      default:   state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Status and handshake outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_ready <= 1'b0;
      fir_cload  <= 1'b0;
      busy       <= 1'b0;
      run        <= 1'b0;
    end else begin
      coef_ready <= (state_d == CL_WAIT);
      fir_cload  <= (state_d == CL_STROBE);
      busy       <= (state_d == CL_WAIT) || (state_d == CL_SETUP) ||
                    (state_d == CL_STROBE);
      run        <= (state_d == RUN);
    end
  end

  // Coefficient counter and CMEM address/data; held until the next accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_cnt  <= '0;
      fir_caddr <= '0;
      fir_cin   <= '0;
    end else begin
      if (state_q == IDLE && cfg_start) coef_cnt <= '0;
      else if (state_q == CL_STROBE)    coef_cnt <= coef_cnt + CAW'(1);
      if (coef_hs) begin
        fir_caddr <= coef_cnt;
        fir_cin   <= coef_data;
      end
    end
  end

  // Frame timer and sample issue; the timer sits at 0 until RUN is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt    <= '0;
      fir_din      <= '0;
      fir_valid_in <= 1'b0;
      udf          <= 1'b0;
    end else begin
      fir_valid_in <= 1'b0;
      if (state_q != RUN) begin
        frame_cnt <= '0;
      end else if (slot) begin
        frame_cnt <= FRAME_RELOAD;
        if (!fifo_empty) begin
          fir_din      <= fifo_head;
          fir_valid_in <= 1'b1;
        end else begin
          udf <= 1'b1;
        end
      end else begin
        frame_cnt <= frame_cnt - FCW'(1);
      end
    end
  end

  // Result capture into the output register, dropping on a full register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fv_q    <= 1'b0;
      fv_q2   <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      ovf     <= 1'b0;
    end else begin
      fv_q  <= fir_valid;
      fv_q2 <= fv_q;
      if (res_evt) begin
        if (!m_valid || m_ready) begin
          m_data  <= fir_dout;
          m_valid <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
- Sequencer that sits in front of the W4823 FIR core.
- After a start command it runs a coefficient-load phase: it streams NTAPS coefficients into the core's CMEM port (caddr/cin/cload) through a valid/ready handshake.
- It then enters run mode. Input samples are buffered in a small FIFO and issued to the core exactly once per FRAME_CYCLES-cycle frame.
- Core results are captured into a valid/ready output register, with overrun and underrun status.

Parameters:
- NTAPS, 64: number of coefficients loaded; caddr width is clog2(NTAPS).
- FRAME_CYCLES, 256: clk cycles per FIR sample slot; minimum 8.
- FIFO_DEPTH, 4: input sample FIFO depth; power of two, minimum 2.
- DW, 16: sample/result width (FP16).
- CW, 17: coefficient width (FP16i).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- cfg_start  in  1  one-cycle pulse; starts coefficient load; honoured only in IDLE.
- coef_valid  in  1  coefficient word valid.
- coef_data  in  CW  coefficient word.
- coef_ready  out  1  coefficient word accepted when coef_valid && coef_ready.
- s_valid  in  1  input sample valid.
- s_data  in  DW  input sample.
- s_ready  out  1  high when the FIFO is not full.
- m_valid  out  1  result valid.
- m_data  out  DW  result.
- m_ready  in  1  result consumer ready.
- fir_cin  out  CW  to core cin.
- fir_caddr  out  clog2(NTAPS)  to core caddr.
- fir_cload  out  1  to core cload; active on its rising edge.
- fir_din  out  DW  to core din.
- fir_valid_in  out  1  one-cycle sample strobe to the core.
- fir_dout  in  DW  from core dout.
- fir_valid  in  1  from core valid (level).
- busy  out  1  high in CLOAD.
- run  out  1  high in RUN.
- ovf  out  1  sticky: a result was dropped.
- udf  out  1  sticky: a frame slot passed with an empty FIFO.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; coefficient counter, frame counter and FIFO pointers 0; m_data 0.
- All outputs are registered.
- State machine:
  - IDLE: cfg_start -> CL_WAIT with coef count 0.
  - CL_WAIT: coef_ready=1. On handshake, register fir_caddr=count and fir_cin=coef_data -> CL_SETUP.
  - CL_SETUP: coef_ready=0, fir_cload=0; one cycle of address/data setup -> CL_STROBE.
  - CL_STROBE: fir_cload=1 for exactly one cycle; count++.
    - If count was NTAPS-1 -> RUN, frame counter 0.
    - Otherwise -> CL_WAIT.
  - Each coefficient therefore costs at least 3 cycles.
  - fir_caddr and fir_cin hold stable from CL_SETUP through the cycle after the strobe.
  - RUN: terminal; leaving it requires reset. cfg_start is ignored outside IDLE.
- Frame counter (RUN only):
  - Counts 0..FRAME_CYCLES-1 and wraps.
  - At count 0: if the FIFO is non-empty, pop it; fir_din = head and fir_valid_in=1 on the next cycle, for one cycle only. fir_din holds until the next issue.
  - At count 0 with an empty FIFO: no strobe; udf set.
- FIFO:
  - Push when s_valid && s_ready.
  - s_ready = !full; it has no combinational dependence on pop.
  - Simultaneous push and pop in the same cycle is legal; the occupancy count is unchanged.
  - Samples are accepted in IDLE and CLOAD too; they are issued only in RUN.
- Result capture:
  - A rising edge of fir_valid (registered previous value) is a result event, detected 1 cycle after the edge.
  - If the output register is empty, or m_ready is high in that cycle, load m_data=fir_dout and set m_valid.
  - Otherwise keep the old data and set ovf.
  - m_valid clears on m_ready when no new result arrives in the same cycle.
  - Edges of fir_valid outside RUN are ignored.
- ovf and udf are cleared only by reset.
- Latency:
  - Sample accept to fir_valid_in: 2 cycles minimum when accepted the cycle before frame count 0; otherwise up to FRAME_CYCLES+1.
  - fir_valid rise to m_valid: 2 cycles.

Decomposition:
- Shared package fir_pkg:
  - Typedef for the state enum (IDLE, CL_WAIT, CL_SETUP, CL_STROBE, RUN).
  - DW/CW defaults.
  - FP16/FP16i widths.
- One sub-module, fir_sample_fifo: synchronous FIFO, DEPTH/WIDTH parameters, full/empty flags, registered outputs. Everything else stays in fir_seq_ctrl.

Test Plan:
- Coefficient load (NTAPS=64): cfg_start, then 64 words with data = 0x100+i and coef_valid held high -> 64 fir_cload pulses; caddr at each pulse = i, cin = 0x100+i; pulses exactly 3 cycles apart; busy falls and run rises after the 64th pulse.
- Issue pacing (FRAME_CYCLES=16): after load, push samples 0x3C00, 0x4000, 0x4200 back-to-back -> fir_valid_in pulses 16 cycles apart with fir_din in that order; no strobe in the 4th frame; udf=1.
- FIFO full (FIFO_DEPTH=4): push 5 samples before RUN -> s_ready=0 after the 4th push; the 5th is accepted only after the first issue; issue order is preserved.
- Result path: core fir_valid rises with fir_dout=0x5140 while m_ready=1 -> m_valid=1 and m_data=0x5140 two cycles later, then cleared after the handshake.
- Overrun: m_ready held 0, two fir_valid rises with 0x1111 then 0x2222 -> m_data stays 0x1111; ovf=1.
- Reset mid-load: assert rst after 10 coefficients -> all outputs 0 immediately; state IDLE; a new cfg_start restarts at caddr 0.
